mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
Memory-side responder for the decoder's memory controls: mem_rd_en, mem_wr_en, mem_byte_en and mem_signed.
- Turns one load/store request from the execute/memory stage into a single Wishbone-classic data-bus transaction.
- Aligns byte lanes and sign/zero-extends load data.
- Flags misaligned accesses, which issue no bus cycle.
- Stalls the pipeline while the access is outstanding.

Parameters:
BYTE_NUM, 8, bytes per data word (4 = RV32, 8 = RV64); DATA_SIZE = 8*BYTE_NUM; OFFSET = log2(BYTE_NUM).
TIMEOUT_CYCLES, 255, ack timeout limit; used only with MEM_ACCESS_TIMEOUT_EN.

Ports:
clock  in  1  system clock; all state updates on rising edge
reset  in  1  asynchronous, active-high reset
mem_rd_en  in  1  load request (from control unit)
mem_wr_en  in  1  store request
mem_byte_en  in  BYTE_NUM  size mask: 'h1, 'h3, 'hF or 'hFF (low-aligned)
mem_signed  in  1  sign-extend load result
addr  in  DATA_SIZE  effective address (ALU result)
wr_data  in  DATA_SIZE  store data, low-aligned
rd_data  out  DATA_SIZE  extended load result, valid with done
done  out  1  one-cycle pulse: access finished or rejected
stall  out  1  pipeline must hold request inputs stable
load_misaligned  out  1  one-cycle pulse with done
store_misaligned  out  1  one-cycle pulse with done
access_fault  out  1  one-cycle pulse with done (timeout only)
wb_cyc  out  1  bus cycle
wb_stb  out  1  bus strobe
wb_we  out  1  bus write
wb_sel  out  BYTE_NUM  byte lane select
wb_adr  out  DATA_SIZE  word-aligned address (low OFFSET bits zero)
wb_dat_o  out  DATA_SIZE  lane-shifted write data
wb_dat_i  in  DATA_SIZE  read data
wb_ack  in  1  bus acknowledge

Behaviour:
- Reset values:
  - Outputs: all outputs 0.
  - State: Idle.
- FSM states: Idle, Access, Done.
- Idle:
  - Request = mem_rd_en | mem_wr_en. If both are high, treat it as a store.
  - Compute misalignment: off = addr[OFFSET-1:0]. The access is misaligned if off is not a multiple of popcount(mem_byte_en).
  - Misaligned request: next state Done. Capture load_misaligned or store_misaligned. Issue no bus cycle.
  - Aligned request: next state Access. Register wb_adr = addr with the low OFFSET bits cleared, wb_sel = mem_byte_en << off, wb_dat_o = wr_data << 8*off, wb_we = store. Assert wb_cyc/wb_stb from the next cycle.
- stall = request in Idle, OR state in {Access}. stall is 0 in Done, which lets the pipeline advance the same cycle done pulses.
- Access:
  - Hold all wb_* outputs stable until wb_ack.
  - On wb_ack: drop cyc/stb in the next cycle.
  - For a load, capture wb_dat_i >> 8*off, masked to the access size. If signed, sign-extend from bit 8*size-1; otherwise zero-extend.
  - Next state Done.
- Done:
  - Pulse done, plus any exception flag, for one cycle.
  - rd_data holds its value until the next load completes.
  - Return to Idle. A new request is sampled in Idle on the next cycle, so the minimum latency is 3 cycles for an aligned access with single-cycle ack.
- Stores: rd_data is unchanged.
- wb_ack seen outside Access: ignored.
- Reset mid-Access: cyc/stb drop asynchronously, no done pulse, state returns to Idle.
- Requests arriving during Access/Done: ignored. Upstream holds them under stall.

Optional Feature:
MEM_ACCESS_TIMEOUT_EN
- Defined:
  - An 8-bit-or-wider counter clears on entry to Access and increments each cycle in Access.
  - On reaching TIMEOUT_CYCLES without wb_ack: abort the cycle (cyc/stb low), go to Done, and pulse access_fault with done.
  - rd_data is unchanged on abort.
- Undefined:
  - No counter; access_fault is tied to 0.
  - Access waits indefinitely for wb_ack.

Decomposition:
- control_unit_pkg gains the mem_access_state_t enum (Idle, Access, Done).
- Sub-module lane_aligner is natural:
  - Combinational.
  - Produces the shifted sel/write data and the shift-back plus extension of read data.
  - Parameterised by BYTE_NUM.
  - Reusable by the instruction-fetch path.

Test Plan:
1. BYTE_NUM=8, lb signed: addr=0x1003, byte_en='h1, wb_dat_i=0x00000000_80000000 → wb_sel='h08, wb_adr=0x1000, rd_data=0xFFFFFFFF_FFFFFF80, done 3 cycles after request.
2. sh: addr=0x2006, byte_en='h3, wr_data=0xBEEF → wb_we=1, wb_sel='hC0, wb_dat_o=0xBEEF0000_00000000, done one cycle after ack, rd_data unchanged.
3. Misaligned: lw with addr=0x3002 → no wb_cyc, load_misaligned=1 and done=1 in the same cycle; sd with addr=0x3004 → store_misaligned.
4. Slow bus: ack delayed 5 cycles → stall held high, wb_* stable throughout, lwu of 0x80000000 at addr=0x4004 yields rd_data=0x00000000_80000000.
5. Reset asserted in Access with wb_cyc=1 → wb_cyc/stb low immediately, no done; the next request after reset completes normally.
6. With MEM_ACCESS_TIMEOUT_EN and TIMEOUT_CYCLES=4, ack never arrives → access_fault and done pulse after 4 Access cycles, bus released.

Source files
------------

// File: rtl/control_unit_pkg.sv
// Shared types and helpers for the control unit and its memory-side responder.
package control_unit_pkg;

  typedef enum logic [1:0] {
    MEM_IDLE   = 2'd0,
    MEM_ACCESS = 2'd1,
    MEM_DONE   = 2'd2
  } mem_access_state_t;

  // Number of set bits in a byte-enable mask (masks up to 16 lanes).
  function automatic logic [4:0] mask_popcount(input logic [15:0] mask);
    logic [4:0] cnt;
    cnt = '0;
    for (int i = 0; i < 16; i++) cnt = cnt + {4'd0, mask[i]};
    return cnt;
  endfunction

endpackage

// File: rtl/mem_access_unit_lane_aligner.sv
// lane_aligner: combinational byte-lane shifting for requests and sign/zero extension for read data.
module lane_aligner
  import control_unit_pkg::*;
#(
  parameter int BYTE_NUM = 8
) (
  input  logic [$clog2(BYTE_NUM)-1:0] req_off,
  input  logic [BYTE_NUM-1:0]         req_byte_en,
  input  logic [8*BYTE_NUM-1:0]       req_data,
  output logic [BYTE_NUM-1:0]         req_sel,
  output logic [8*BYTE_NUM-1:0]       req_data_shifted,
  output logic                        misaligned,
  input  logic [$clog2(BYTE_NUM)-1:0] rd_off,
  input  logic [BYTE_NUM-1:0]         rd_byte_en,
  input  logic                        rd_signed,
  input  logic [8*BYTE_NUM-1:0]       rd_raw,
  output logic [8*BYTE_NUM-1:0]       rd_ext
);

  localparam int OFFSET    = $clog2(BYTE_NUM);
  localparam int DATA_SIZE = 8 * BYTE_NUM;

  logic [4:0]           size;
  logic [OFFSET-1:0]    size_m1;
  logic [DATA_SIZE-1:0] rd_shifted;
  logic                 sign_bit;

  // Legal sizes are powers of two, so "offset multiple of size" is a mask test.
  assign size       = mask_popcount(16'(req_byte_en));
  assign size_m1    = OFFSET'(size - 5'd1);
  assign misaligned = |(req_off & size_m1);

  assign req_sel          = req_byte_en << req_off;
  assign req_data_shifted = req_data << {req_off, 3'b000};
  assign rd_shifted       = rd_raw >> {rd_off, 3'b000};

  // Sign comes from the MSB of the highest enabled byte.
  always_comb begin
    sign_bit = 1'b0;
    for (int i = 0; i < BYTE_NUM; i++) begin
      if (rd_byte_en[i]) sign_bit = rd_shifted[8*i+7];
    end
    rd_ext = '0;
    for (int i = 0; i < BYTE_NUM; i++) begin
      rd_ext[8*i +: 8] = rd_byte_en[i] ? rd_shifted[8*i +: 8] : {8{rd_signed & sign_bit}};
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store responder: one Wishbone-classic cycle per aligned request, misaligned requests rejected.
// Optional ack timeout enabled by defining MEM_ACCESS_TIMEOUT_EN.
module mem_access_unit
  import control_unit_pkg::*;
#(
  parameter int BYTE_NUM       = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  mem_rd_en,
  input  logic                  mem_wr_en,
  input  logic [BYTE_NUM-1:0]   mem_byte_en,
  input  logic                  mem_signed,
  input  logic [8*BYTE_NUM-1:0] addr,
  input  logic [8*BYTE_NUM-1:0] wr_data,
  output logic [8*BYTE_NUM-1:0] rd_data,
  output logic                  done,
  output logic                  stall,
  output logic                  load_misaligned,
  output logic                  store_misaligned,
  output logic                  access_fault,
  output logic                  wb_cyc,
  output logic                  wb_stb,
  output logic                  wb_we,
  output logic [BYTE_NUM-1:0]   wb_sel,
  output logic [8*BYTE_NUM-1:0] wb_adr,
  output logic [8*BYTE_NUM-1:0] wb_dat_o,
  input  logic [8*BYTE_NUM-1:0] wb_dat_i,
  input  logic                  wb_ack
);

  localparam int OFFSET    = $clog2(BYTE_NUM);
  localparam int DATA_SIZE = 8 * BYTE_NUM;

  if (BYTE_NUM < 2 || BYTE_NUM > 16) begin : g_bad_byte_num
    $error("mem_access_unit: BYTE_NUM must be 2..16");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("mem_access_unit: TIMEOUT_CYCLES must be at least 1");
  end

  mem_access_state_t state_q, state_d;

  logic                 req, is_store, req_misaligned;
  logic [OFFSET-1:0]    req_off, off_q;
  logic [BYTE_NUM-1:0]  req_sel, be_q;
  logic [DATA_SIZE-1:0] req_data_shifted, rd_ext;
  logic                 signed_q;
  logic                 capture, load_finish, finish, ld_mis_d, st_mis_d, timeout_hit;

  assign req      = mem_rd_en | mem_wr_en;
  assign is_store = mem_wr_en;
  assign req_off  = addr[OFFSET-1:0];

  lane_aligner #(.BYTE_NUM(BYTE_NUM)) u_lane_aligner (
    .req_off          (req_off),
    .req_byte_en      (mem_byte_en),
    .req_data         (wr_data),
    .req_sel          (req_sel),
    .req_data_shifted (req_data_shifted),
    .misaligned       (req_misaligned),
    .rd_off           (off_q),
    .rd_byte_en       (be_q),
    .rd_signed        (signed_q),
    .rd_raw           (wb_dat_i),
    .rd_ext           (rd_ext)
  );

  always_comb begin
    state_d     = state_q;
    stall       = 1'b0;
    capture     = 1'b0;
    load_finish = 1'b0;
    finish      = 1'b0;
    ld_mis_d    = 1'b0;
    st_mis_d    = 1'b0;
    unique case (state_q)
      MEM_IDLE: begin
        if (req) begin
          stall = 1'b1;
          if (req_misaligned) begin
            state_d  = MEM_DONE;
            finish   = 1'b1;
            ld_mis_d = ~is_store;
            st_mis_d = is_store;
          end else begin
            state_d = MEM_ACCESS;
            capture = 1'b1;
          end
        end
      end
      MEM_ACCESS: begin
        stall = 1'b1;
        if (wb_ack) begin
          state_d     = MEM_DONE;
          finish      = 1'b1;
          load_finish = ~wb_we;
        end else if (timeout_hit) begin
          state_d = MEM_DONE;
          finish  = 1'b1;
        end
      end
      MEM_DONE: state_d = MEM_IDLE;
      default:  state_d = MEM_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q          <= MEM_IDLE;
      done             <= 1'b0;
      load_misaligned  <= 1'b0;
      store_misaligned <= 1'b0;
      wb_cyc           <= 1'b0;
      wb_stb           <= 1'b0;
      wb_we            <= 1'b0;
      wb_sel           <= '0;
      wb_adr           <= '0;
      wb_dat_o         <= '0;
      off_q            <= '0;
      be_q             <= '0;
      signed_q         <= 1'b0;
      rd_data          <= '0;
    end else begin
      state_q          <= state_d;
      done             <= finish;
      load_misaligned  <= ld_mis_d;
      store_misaligned <= st_mis_d;
      if (capture) begin
        wb_cyc   <= 1'b1;
        wb_stb   <= 1'b1;
        wb_we    <= is_store;
        wb_sel   <= req_sel;
        wb_adr   <= {addr[DATA_SIZE-1:OFFSET], {OFFSET{1'b0}}};
        wb_dat_o <= req_data_shifted;
        off_q    <= req_off;
        be_q     <= mem_byte_en;
        signed_q <= mem_signed;
      end else if (finish && state_q == MEM_ACCESS) begin
        wb_cyc <= 1'b0;
        wb_stb <= 1'b0;
      end
      if (load_finish) rd_data <= rd_ext;
    end
  end

`ifdef MEM_ACCESS_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [CNT_W-1:0] timeout_cnt;

  // Counter reads k during the (k+1)th Access cycle; it would reach TIMEOUT_CYCLES on the abort edge.
  assign timeout_hit = (timeout_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      timeout_cnt  <= '0;
      access_fault <= 1'b0;
    end else begin
      access_fault <= (state_q == MEM_ACCESS) && !wb_ack && timeout_hit;
      if (capture) timeout_cnt <= '0;
      else if (state_q == MEM_ACCESS) timeout_cnt <= timeout_cnt + CNT_W'(1);
    end
  end
`else
  assign timeout_hit  = 1'b0;
  assign access_fault = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized scoreboard bench for mem_access_unit with a Wishbone slave responder.
module tb_mem_access_unit;
  localparam int BN = 8;
  localparam int TO = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        mem_rd_en, mem_wr_en, mem_signed;
  logic [7:0]  mem_byte_en;
  logic [63:0] addr, wr_data, rd_data;
  logic        done, stall, load_misaligned, store_misaligned, access_fault;
  logic        wb_cyc, wb_stb, wb_we, wb_ack;
  logic [7:0]  wb_sel;
  logic [63:0] wb_adr, wb_dat_o, wb_dat_i;

  always #5 clock = ~clock;

  mem_access_unit #(.BYTE_NUM(BN), .TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .reset(reset),
    .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_byte_en(mem_byte_en),
    .mem_signed(mem_signed), .addr(addr), .wr_data(wr_data), .rd_data(rd_data),
    .done(done), .stall(stall), .load_misaligned(load_misaligned),
    .store_misaligned(store_misaligned), .access_fault(access_fault),
    .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_sel(wb_sel),
    .wb_adr(wb_adr), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_ack(wb_ack)
  );

  typedef struct { logic [63:0] adr; logic [7:0] sel; logic [63:0] dat; logic we; } bus_exp_t;
  typedef struct { logic [63:0] rd; logic lm; logic sm; logic af; } resp_exp_t;

  bus_exp_t    bus_q[$];
  resp_exp_t   resp_q[$];
  int          n_total = 0;
  int          n_pass  = 0;
  logic [63:0] model_rd = '0;
  logic [63:0] bus_rword = '0;
  int          bus_delay = 0;
  bit          bus_mute  = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Slave: acks after bus_delay cycles unless muted.
  initial begin
    wb_ack   = 1'b0;
    wb_dat_i = '0;
    forever begin
      @(posedge clock); #1;
      if (wb_cyc && wb_stb && !bus_mute) begin
        for (int n = 0; n < bus_delay && wb_cyc; n++) begin
          @(posedge clock); #1;
        end
        if (wb_cyc) begin
          wb_ack   = 1'b1;
          wb_dat_i = bus_rword;
          @(posedge clock); #1;
          wb_ack   = 1'b0;
          wb_dat_i = {$urandom(), $urandom()};
        end
      end
    end
  end

  // Bus monitor: first cycle of each wb cycle against expectation, then stability until release.
  initial begin
    logic        cyc_prev, stable;
    logic [63:0] s_adr, s_dat;
    logic [7:0]  s_sel;
    logic        s_we;
    bus_exp_t    e;
    cyc_prev = 1'b0;
    stable   = 1'b1;
    s_adr = '0; s_dat = '0; s_sel = '0; s_we = 1'b0;
    forever begin
      @(negedge clock);
      if (wb_cyc && !cyc_prev) begin
        if (bus_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_bus_cycle: wb_cyc=1 adr=%h, required no cycle", wb_adr);
        end else begin
          e = bus_q.pop_front();
          check("wb_adr", wb_adr, e.adr);
          check("wb_sel", 64'(wb_sel), 64'(e.sel));
          check("wb_dat_o", wb_dat_o, e.dat);
          check("wb_we", 64'(wb_we), 64'(e.we));
          check("wb_stb", 64'(wb_stb), 64'd1);
        end
        s_adr = wb_adr; s_dat = wb_dat_o; s_sel = wb_sel; s_we = wb_we;
        stable = 1'b1;
      end else if (wb_cyc) begin
        if (wb_adr !== s_adr || wb_dat_o !== s_dat || wb_sel !== s_sel || wb_we !== s_we || !wb_stb)
          stable = 1'b0;
      end else if (cyc_prev) begin
        check("bus_stable", 64'(stable), 64'd1);
      end
      cyc_prev = wb_cyc;
    end
  end

  // Response monitor.
  initial begin
    resp_exp_t r;
    forever begin
      @(negedge clock);
      if (done) begin
        if (resp_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_done: done=1, required 0");
        end else begin
          r = resp_q.pop_front();
          check("rd_data", rd_data, r.rd);
          check("load_misaligned", 64'(load_misaligned), 64'(r.lm));
          check("store_misaligned", 64'(store_misaligned), 64'(r.sm));
          check("access_fault", 64'(access_fault), 64'(r.af));
        end
      end else if (load_misaligned || store_misaligned || access_fault) begin
        n_total++;
        $display("FAIL flag_without_done: flags=%b%b%b, required 000",
                 load_misaligned, store_misaligned, access_fault);
      end
    end
  end

  task automatic run_req(input logic rd, input logic wr, input logic sgn, input logic [7:0] be,
                         input logic [63:0] a, input logic [63:0] wd, input logic [63:0] rw,
                         input int dly, input bit timeout);
    int          n, off, lat, exp_lat;
    bit          mis, stall_ok;
    logic [63:0] val, mask;
    resp_exp_t   r;
    bus_exp_t    b;
    n = 0;
    for (int i = 0; i < 8; i++) n += int'(be[i]);
    off = int'(a[2:0]);
    mis = (off % n) != 0;
    r.lm = mis && !wr;
    r.sm = mis && wr;
    r.af = 1'b0;
    if (mis) begin
      exp_lat = 1;
    end else begin
      b.adr = a & ~64'h7;
      b.sel = be << off;
      b.dat = wd << (8 * off);
      b.we  = wr;
      bus_q.push_back(b);
      if (timeout) begin
        r.af    = 1'b1;
        exp_lat = 1 + TO;
      end else begin
        exp_lat = 2 + dly;
        if (!wr) begin
          val = rw >> (8 * off);
          if (n < 8) begin
            mask = (64'h1 << (8 * n)) - 64'h1;
            val  = val & mask;
            if (sgn && val[8*n-1]) val = val | ~mask;
          end
          model_rd = val;
        end
      end
    end
    r.rd = model_rd;
    resp_q.push_back(r);
    bus_rword = rw;
    bus_delay = dly;
    bus_mute  = timeout;
    @(posedge clock); #1;
    mem_rd_en = rd; mem_wr_en = wr; mem_signed = sgn; mem_byte_en = be;
    addr = a; wr_data = wd;
    stall_ok = 1'b1;
    lat = 0;
    @(negedge clock);
    if (!stall) stall_ok = 1'b0;
    while (lat < 400) begin
      @(posedge clock);
      lat++;
      @(negedge clock);
      if (done) break;
      if (!stall) stall_ok = 1'b0;
    end
    check("latency", 64'(lat), 64'(exp_lat));
    check("stall_while_busy", 64'(stall_ok), 64'd1);
    check("stall_in_done", 64'(stall), 64'd0);
    @(posedge clock); #1;
    mem_rd_en = 1'b0; mem_wr_en = 1'b0; mem_signed = 1'b0; mem_byte_en = '0;
  endtask

  task automatic reset_mid_access();
    bus_exp_t b;
    bus_mute = 1'b1;
    b.adr = 64'h6000; b.sel = 8'h0F; b.dat = 64'h0; b.we = 1'b0;
    bus_q.push_back(b);
    @(posedge clock); #1;
    mem_rd_en = 1'b1; mem_wr_en = 1'b0; mem_signed = 1'b0; mem_byte_en = 8'h0F;
    addr = 64'h6000; wr_data = 64'h0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      if (wb_cyc) break;
    end
    check("cyc_before_reset", 64'(wb_cyc), 64'd1);
    @(negedge clock); #2;
    reset = 1'b1;
    #1;
    check("cyc_after_reset", 64'(wb_cyc), 64'd0);
    check("stb_after_reset", 64'(wb_stb), 64'd0);
    check("done_after_reset", 64'(done), 64'd0);
    check("rd_after_reset", rd_data, 64'd0);
    model_rd = '0;
    mem_rd_en = 1'b0; mem_byte_en = '0;
    @(negedge clock); @(negedge clock);
    reset = 1'b0;
    bus_mute = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    logic [7:0]  be;
    logic [63:0] a;
    logic        rd, wr;
    int          n, off;
    reset = 1'b1;
    mem_rd_en = 1'b0; mem_wr_en = 1'b0; mem_signed = 1'b0; mem_byte_en = '0;
    addr = '0; wr_data = '0;
    @(negedge clock); @(negedge clock);
    check("rst_done", 64'(done), 64'd0);
    check("rst_stall", 64'(stall), 64'd0);
    check("rst_flags", 64'({load_misaligned, store_misaligned, access_fault}), 64'd0);
    check("rst_cyc_stb_we", 64'({wb_cyc, wb_stb, wb_we}), 64'd0);
    check("rst_sel", 64'(wb_sel), 64'd0);
    check("rst_adr", wb_adr, 64'd0);
    check("rst_dat_o", wb_dat_o, 64'd0);
    check("rst_rd_data", rd_data, 64'd0);
    reset = 1'b0;

    run_req(1'b1, 1'b0, 1'b1, 8'h01, 64'h1003, 64'h0, 64'h00000000_80000000, 0, 1'b0);
    check("lb_signed", rd_data, 64'hFFFFFFFF_FFFFFF80);
    run_req(1'b0, 1'b1, 1'b0, 8'h03, 64'h2006, 64'hBEEF, 64'h1234_5678_9ABC_DEF0, 0, 1'b0);
    check("sh_rd_unchanged", rd_data, 64'hFFFFFFFF_FFFFFF80);
    run_req(1'b1, 1'b0, 1'b0, 8'h0F, 64'h3002, 64'h0, 64'h0, 0, 1'b0);
    run_req(1'b0, 1'b1, 1'b0, 8'hFF, 64'h3004, 64'h55, 64'h0, 0, 1'b0);
    run_req(1'b1, 1'b0, 1'b0, 8'h0F, 64'h4004, 64'h0, 64'h80000000_00000000, 5, 1'b0);
    check("lwu_slow", rd_data, 64'h00000000_80000000);
    reset_mid_access();
    run_req(1'b1, 1'b0, 1'b1, 8'h03, 64'h7002, 64'h0, 64'h0000_0000_8001_0000, 1, 1'b0);
    check("lh_after_reset", rd_data, 64'hFFFFFFFF_FFFF8001);
`ifdef MEM_ACCESS_TIMEOUT_EN
    run_req(1'b1, 1'b0, 1'b0, 8'h0F, 64'h5000, 64'h0, 64'hDEAD_BEEF_DEAD_BEEF, 0, 1'b1);
    check("timeout_rd_unchanged", rd_data, 64'hFFFFFFFF_FFFF8001);
    check("timeout_bus_released", 64'(wb_cyc), 64'd0);
`endif

    for (int i = 0; i < 150; i++) begin
      n = 1 << $urandom_range(0, 3);
      be = 8'((16'h1 << n) - 16'h1);
      if ($urandom_range(0, 3) != 0) off = n * int'($urandom_range(0, (8 / n) - 1));
      else off = int'($urandom_range(0, 7));
      a = ({$urandom(), $urandom()} & ~64'h7) | 64'(off);
      rd = 1'($urandom_range(0, 1));
      wr = rd ? 1'($urandom_range(0, 1)) : 1'b1;
      run_req(rd, wr, 1'($urandom_range(0, 1)), be, a, {$urandom(), $urandom()},
              {$urandom(), $urandom()}, int'($urandom_range(0, 3)), 1'b0);
    end

    repeat (5) @(negedge clock);
    check("bus_q_drained", 64'(bus_q.size()), 64'd0);
    check("resp_q_drained", 64'(resp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
